// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the Register_Bank write port between the ALU (A)
// and load (M) writeback paths, with a pending-write scoreboard for decode stalls.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              regWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_M = 1'b1
    } grant_e;

    grant_e            lastGrant, lastGrantNext;
    logic [NREG-1:0]   sb, sbNext;
    logic              xferA, xferM, xfer;
    logic [ADDR_W-1:0] xAddr;
    logic [DATA_W-1:0] xData;

    // Ready depends only on the valids and lastGrant, never on addr/data.
    always_comb begin
        a_ready = a_valid & (~m_valid | (lastGrant == GRANT_M));
        m_ready = m_valid & (~a_valid | (lastGrant == GRANT_A));
        xferA   = a_valid & a_ready;
        xferM   = m_valid & m_ready;
        xfer    = xferA | xferM;
        xAddr   = xferM ? m_addr : a_addr;
        xData   = xferM ? m_data : a_data;
    end

    always_comb begin
        lastGrantNext = lastGrant;
        if (xferA) begin
            lastGrantNext = GRANT_A;
        end else if (xferM) begin
            lastGrantNext = GRANT_M;
        end
    end

    // Clear first, then set, so a same-cycle reservation of a retiring register wins.
    always_comb begin
        sbNext = sb;
        if (xfer) begin
            sbNext[xAddr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            sbNext[rsv_addr] = 1'b1;
        end
        sbNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastGrant <= GRANT_M;
            sb        <= '0;
            regWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            lastGrant <= lastGrantNext;
            sb        <= sbNext;
            regWrite  <= xfer && (xAddr != '0);
            if (xfer) begin
                WriteReg  <= xAddr;
                WriteData <= xData;
            end
        end
    end

    always_comb begin
        busy1 = sb[q_addr1] | (regWrite & (WriteReg == q_addr1) & (q_addr1 != '0));
        busy2 = sb[q_addr2] | (regWrite & (WriteReg == q_addr2) & (q_addr2 != '0));
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a behavioural model predicts grants,
// bank writes and pending-register state; a monitor checks every bank cycle.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, m_valid, rsv_valid;
    logic        a_ready, m_ready, busy1, busy2, regWrite;
    logic [4:0]  a_addr, m_addr, rsv_addr, q_addr1, q_addr2, WriteReg;
    logic [31:0] a_data, m_data, WriteData;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         we;
        logic [4:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];

    // Behavioural model state
    int         mLast;      // 1 = A was last granted, 2 = M
    bit         sbM[32];
    bit         outWe;
    logic [4:0] outAddr;

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .busy1(busy1), .busy2(busy2),
        .regWrite(regWrite), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mLast = 2;
        foreach (sbM[i]) sbM[i] = 1'b0;
        outWe = 1'b0;
        outAddr = '0;
        expQ.delete();
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, predict the bank write.
    task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md,
                         input bit rv, input logic [4:0] ra,
                         input logic [4:0] q1, input logic [4:0] q2,
                         output int win, output bit dutMReady);
        exp_t e;
        logic [4:0] wa;
        logic [31:0] wd;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        m_valid = mv; m_addr = ma; m_data = md;
        rsv_valid = rv; rsv_addr = ra;
        q_addr1 = q1; q_addr2 = q2;
        #1;
        if (av && mv) win = (mLast == 2) ? 1 : 2;
        else if (av)  win = 1;
        else if (mv)  win = 2;
        else          win = 0;
        chk("a_ready", a_ready, (win == 1));
        chk("m_ready", m_ready, (win == 2));
        dutMReady = m_ready;
        chk("busy1", busy1, sbM[q1] || (outWe && outAddr == q1 && q1 != 0));
        chk("busy2", busy2, sbM[q2] || (outWe && outAddr == q2 && q2 != 0));
        wa = (win == 2) ? ma : aa;
        wd = (win == 2) ? md : ad;
        e.we = (win != 0) && (wa != 0);
        e.addr = wa;
        e.data = wd;
        expQ.push_back(e);
        if (win != 0) begin
            mLast = win;
            sbM[wa] = 1'b0;
        end
        if (rv && ra != 0) sbM[ra] = 1'b1;
        outWe = e.we;
        if (e.we) outAddr = wa;
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        int w; bit r;
        cycle(0, '0, '0, 0, '0, '0, 0, '0, q1, q2, w, r);
    endtask

    // Monitor: compares the bank port one step after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("regWrite", regWrite, e.we);
                if (e.we) begin
                    chk("WriteReg", WriteReg, e.addr);
                    chk("WriteData", WriteData, e.data);
                end
            end
        end
    end

    initial begin
        int w, aIdx, mIdx, mWait;
        bit mr;
        bit aV, mV;
        logic [4:0] aA, mA;
        logic [31:0] aD, mD;

        rst = 1'b0;
        a_valid = 0; m_valid = 0; rsv_valid = 0;
        a_addr = '0; m_addr = '0; rsv_addr = '0; a_data = '0; m_data = '0;
        q_addr1 = 5'd3; q_addr2 = 5'd0;
        modelReset();
        #1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_WriteReg", WriteReg, 0);
        chk("rst_WriteData", WriteData, 0);
        chk("rst_busy1", busy1, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single ALU write
        cycle(1, 5'd1, 32'h0000000F, 0, '0, '0, 0, '0, 5'd1, 5'd0, w, mr);
        idle(5'd1, 5'd2);

        // Asynchronous reset with a write in flight and a reservation pending
        cycle(0, '0, '0, 0, '0, '0, 1, 5'd9, 5'd9, 5'd3, w, mr);
        cycle(1, 5'd3, 32'hCAFEF00D, 0, '0, '0, 0, '0, 5'd9, 5'd3, w, mr);
        @(posedge clk);
        #2;
        a_valid = 0; m_valid = 0; rsv_valid = 0;
        rst = 1'b0;
        #1;
        chk("async_regWrite", regWrite, 0);
        chk("async_WriteReg", WriteReg, 0);
        chk("async_WriteData", WriteData, 0);
        chk("async_busy1", busy1, 0);
        chk("async_busy2", busy2, 0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;

        // Contention from reset: A R5.., M R16.. must alternate starting with A
        aIdx = 0; mIdx = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 5'(5 + aIdx), 32'h0A00_0000 + aIdx, 1, 5'(16 + mIdx), 32'h0B00_0000 + mIdx,
                  0, '0, 5'd5, 5'd16, w, mr);
            chk("rr_order", w, (i % 2 == 0) ? 1 : 2);
            if (w == 1) aIdx++;
            if (w == 2) mIdx++;
        end
        idle('0, '0);

        // Register 0 load write
        cycle(0, '0, '0, 1, 5'd0, 32'h0000DEAD, 0, '0, 5'd0, 5'd0, w, mr);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Scoreboard: reserve R7, retire it, then reserve and retire in one cycle
        cycle(0, '0, '0, 0, '0, '0, 1, 5'd7, 5'd7, 5'd0, w, mr);
        idle(5'd7, 5'd0);
        cycle(1, 5'd7, 32'h77, 0, '0, '0, 0, '0, 5'd7, 5'd7, w, mr);
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);
        cycle(1, 5'd7, 32'h78, 0, '0, '0, 1, 5'd7, 5'd7, 5'd1, w, mr);
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);
        cycle(0, '0, '0, 1, 5'd7, 32'h79, 0, '0, 5'd7, 5'd0, w, mr);
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);

        // Stall fairness: M always requesting, A toggles randomly
        mWait = 0; mIdx = 0;
        for (int i = 0; i < 24; i++) begin
            aV = 1'($urandom % 2);
            cycle(aV, 5'(1 + $urandom % 31), $urandom, 1, 5'(8 + mIdx % 8), 32'h1000 + mIdx,
                  0, '0, 5'($urandom % 32), 5'($urandom % 32), w, mr);
            if (mr) begin
                mWait = 0;
                mIdx++;
            end else begin
                mWait++;
            end
            chk("m_wait_bound", (mWait <= 1), 1);
        end
        idle('0, '0);

        // Randomized traffic; requests hold addr/data until transferred
        aV = 0; mV = 0; aA = '0; mA = '0; aD = '0; mD = '0;
        for (int i = 0; i < 400; i++) begin
            if (!aV) begin
                aV = 1'($urandom % 2); aA = 5'($urandom % 8); aD = $urandom;
            end
            if (!mV) begin
                mV = 1'($urandom % 2); mA = 5'($urandom % 8); mD = $urandom;
            end
            cycle(aV, aA, aD, mV, mA, mD, 1'($urandom % 4 == 0), 5'($urandom % 8),
                  5'($urandom % 8), 5'($urandom % 8), w, mr);
            if (w == 1) aV = 0;
            if (w == 2) mV = 0;
        end
        idle('0, '0);
        idle('0, '0);
        @(posedge clk);
        #3;
        chk("queue_drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
